// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// scheduler states and default latencies.
package mdu_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mdu_sched_if.sv
// Pipeline-facing bundle of the MDU scheduler: E-stage issue, D-stage hazard
// query and the HI/LO read path.
interface mdu_sched_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        rd_sel;
    logic        D_uses_md;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rd;

    modport master (
        output start, md_op, src_a, src_b, rd_sel, D_uses_md,
        input  busy, stall_md, hi, lo, md_rd
    );

    modport slave (
        input  start, md_op, src_a, src_b, rd_sel, D_uses_md,
        output busy, stall_md, hi, lo, md_rd
    );
endinterface

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 64-bit products and quotient/remainder pairs,
// with divide-by-zero flagged so the scheduler can suppress the commit.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        divisor;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic [31:0]        q_s;
    logic [31:0]        r_s;

    always_comb begin
        prod_s  = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
        prod_u  = {32'd0, src_a} * {32'd0, src_b};
        // A zero divisor is swapped for 1 so the dividers never produce X;
        // the result is discarded anyway.
        divisor = (src_b == 32'd0) ? 32'd1 : src_b;
        // Signed division on magnitudes: 0x80000000 negates to itself, which is
        // the correct unsigned magnitude, so MIN/-1 wraps to 0x80000000 cleanly.
        a_mag   = src_a[31] ? (~src_a + 32'd1) : src_a;
        b_mag   = divisor[31] ? (~divisor + 32'd1) : divisor;
        q_mag   = a_mag / b_mag;
        r_mag   = a_mag % b_mag;
        q_s     = (src_a[31] ^ divisor[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s     = src_a[31] ? (~r_mag + 32'd1) : r_mag;

        res_hi  = 32'd0;
        res_lo  = 32'd0;
        div0    = 1'b0;
        case (md_op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                res_lo = q_s;
                res_hi = r_s;
                div0   = (src_b == 32'd0);
            end
            MD_DIVU: begin
                res_lo = src_a / divisor;
                res_hi = src_a % divisor;
                div0   = (src_b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_sched.sv
// MDU scheduler: computes the result at issue, holds it pending for a fixed
// latency, then commits to HI/LO; raises the D-stage stall while in flight.
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    mdu_sched_if.slave  bus
);

    localparam int CNT_W = $clog2(max_int(MUL_LAT, DIV_LAT) + 1);

    state_e           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;
    logic [31:0]      pend_hi_reg;
    logic [31:0]      pend_lo_reg;
    logic             pend_div0_reg;

    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             div0;
    logic             is_arith;

    mdu_arith u_arith (
        .md_op  (bus.md_op),
        .src_a  (bus.src_a),
        .src_b  (bus.src_b),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    assign is_arith = ~bus.md_op[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            hi_reg        <= 32'd0;
            lo_reg        <= 32'd0;
            pend_hi_reg   <= 32'd0;
            pend_lo_reg   <= 32'd0;
            pend_div0_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        if (is_arith) begin
                            pend_hi_reg   <= res_hi;
                            pend_lo_reg   <= res_lo;
                            pend_div0_reg <= div0;
                            cnt_reg       <= bus.md_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                            state_reg     <= RUN;
                            busy_reg      <= 1'b1;
                        end else if (bus.md_op == MD_MTHI) begin
                            hi_reg <= bus.src_a;
                        end else if (bus.md_op == MD_MTLO) begin
                            lo_reg <= bus.src_a;
                        end
                    end
                end
                RUN: begin
                    // A start arriving here is ignored: the stall keeps it from happening.
                    if (cnt_reg == CNT_W'(1)) begin
                        if (!pend_div0_reg) begin
                            hi_reg <= pend_hi_reg;
                            lo_reg <= pend_lo_reg;
                        end
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.stall_md = bus.D_uses_md & (busy_reg | (bus.start & is_arith));
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
    assign bus.md_rd    = bus.rd_sel ? lo_reg : hi_reg;

endmodule
